weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/wload_pkg.sv | 16 +
 rtl/weight_loader.sv | 114 +++++++++++
 tb/tb_weight_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wload_pkg.sv
// Shared types for the weight loader: FSM state encoding and its enum.
package wload_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        LOAD  = ST_LOAD,
        DONE  = ST_DONE
    } wload_state_e;

endpackage

// File: rtl/weight_loader.sv
// Streams ROWS signed weights into a daisy-chained weight register column.
// Define WLOAD_CLEAR_EN to prefix every load with a one-cycle chain clear.
module weight_loader
    import wload_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROWS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    i_ready,
    output logic signed [WIDTH-1:0] o_data,
    output logic                    o_en,
    output logic                    o_clr,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned     CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(ROWS - 1);

    wload_state_e            state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    en_q, en_d;
    logic                    done_q, done_d;
    logic                    accept;

    // abort masks the handshake so a weight offered in that cycle is dropped
    assign i_ready = (state_q == LOAD) && !abort;
    assign accept  = i_valid && i_ready;
    assign busy    = (state_q != IDLE);
    assign o_data  = data_q;
    assign o_en    = en_q;
    assign done    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef WLOAD_CLEAR_EN
                        state_d = CLEAR;
`else
                        state_d = LOAD;
`endif
                    end
                end
                CLEAR: state_d = LOAD;
                LOAD: begin
                    if (accept) begin
                        data_d = i_data;
                        en_d   = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

`ifdef WLOAD_CLEAR_EN
    logic clr_q;

    // clear pulse lands in the first LOAD cycle, before any o_en can follow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= 1'b0;
        end else begin
            clr_q <= (state_q == CLEAR) && !abort;
        end
    end

    assign o_clr = clr_q;
`else
    assign o_clr = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: directed vector table, async reset
// sequence, and randomized traffic against a transaction-level model.
module tb_weight_loader;

    localparam int WIDTH = 8;
    localparam int ROWS  = 4;
`ifdef WLOAD_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    abort;
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_data;
    logic                    i_ready;
    logic signed [WIDTH-1:0] o_data;
    logic                    o_en;
    logic                    o_clr;
    logic                    busy;
    logic                    done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    weight_loader #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_en    (o_en),
        .o_clr   (o_clr),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic                    start;
        logic                    abort;
        logic                    valid;
        logic signed [WIDTH-1:0] data;
        logic                    rdy;
        logic                    en;
        logic signed [WIDTH-1:0] od;
        logic                    clr;
        logic                    done;
        logic                    busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int s, int a, int v, int d, int rdy, int en, int od,
                                int clr, int dn, int bz);
        vec_t r;
        r.start = (s != 0);
        r.abort = (a != 0);
        r.valid = (v != 0);
        r.data  = WIDTH'(d);
        r.rdy   = (rdy != 0);
        r.en    = (en != 0);
        r.od    = WIDTH'(od);
        r.clr   = (clr != 0);
        r.done  = (dn != 0);
        r.busy  = (bz != 0);
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic en, input logic signed [WIDTH-1:0] od,
                            input logic clr, input logic dn, input logic bz);
        chk({tag, "_en"},   o_en,   en);
        chk({tag, "_data"}, o_data, od);
        chk({tag, "_clr"},  o_clr,  clr);
        chk({tag, "_done"}, done,   dn);
        chk({tag, "_busy"}, busy,   bz);
        chk({tag, "_excl"}, o_en & o_clr, 1'b0);
    endtask

    task automatic step(input logic s, input logic a, input logic v,
                        input logic signed [WIDTH-1:0] d);
        @(negedge clk);
        start = s; abort = a; i_valid = v; i_data = d;
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: whether a load is open, how many cycles
    // remain before weights may flow, and how many weights this load has taken.
    bit                      m_busy;
    int                      m_pre;
    int                      m_taken;
    logic signed [WIDTH-1:0] m_data;
    bit                      m_en, m_clr, m_done;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; i_valid = 1'b0; i_data = '0;
        #1;
        chk("reset_ready", i_ready, 1'b0);
        chk_outs("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back load
        add(1,0,0,0,   0,0,0,   0,0,1);
        if (CLR_EN) add(0,0,0,0, 0,0,0, 1,0,1);
        add(0,0,1,1,   1,1,1,   0,0,1);
        add(0,0,1,-2,  1,1,-2,  0,0,1);
        add(0,0,1,3,   1,1,3,   0,0,1);
        add(0,0,1,-4,  1,1,-4,  0,1,1);
        add(0,0,1,9,   0,0,-4,  0,0,0);
        add(0,0,0,0,   0,0,-4,  0,0,0);
        // valid gap, start while loading, start+abort in idle
        add(1,0,0,0,   0,0,-4,  0,0,1);
        if (CLR_EN) add(0,0,1,77, 0,0,-4, 1,0,1);
        add(0,0,1,1,   1,1,1,   0,0,1);
        add(0,0,1,-2,  1,1,-2,  0,0,1);
        add(0,0,0,5,   1,0,-2,  0,0,1);
        add(1,0,0,5,   1,0,-2,  0,0,1);
        add(0,0,0,5,   1,0,-2,  0,0,1);
        add(0,0,1,3,   1,1,3,   0,0,1);
        add(1,0,1,-4,  1,1,-4,  0,1,1);
        add(0,0,0,0,   0,0,-4,  0,0,0);
        add(1,1,0,0,   0,0,-4,  0,0,0);
        add(0,0,1,6,   0,0,-4,  0,0,0);
        // abort after two acceptances, then a fresh load
        add(1,0,0,0,   0,0,-4,  0,0,1);
        if (CLR_EN) add(0,0,0,0, 0,0,-4, 1,0,1);
        add(0,0,1,10,  1,1,10,  0,0,1);
        add(0,0,1,20,  1,1,20,  0,0,1);
        add(0,1,1,30,  0,0,20,  0,0,0);
        add(0,0,1,40,  0,0,20,  0,0,0);
        add(1,0,0,0,   0,0,20,  0,0,1);
        if (CLR_EN) add(0,0,0,0, 0,0,20, 1,0,1);
        add(0,0,1,11,  1,1,11,  0,0,1);
        add(0,0,1,12,  1,1,12,  0,0,1);
        add(0,0,1,13,  1,1,13,  0,0,1);
        add(0,0,1,14,  1,1,14,  0,1,1);
        add(0,0,0,0,   0,0,14,  0,0,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; abort = vecs[i].abort;
            i_valid = vecs[i].valid; i_data = vecs[i].data;
            #1;
            chk($sformatf("vec%0d_ready", i), i_ready, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].od, vecs[i].clr,
                     vecs[i].done, vecs[i].busy);
        end

        // asynchronous reset in the middle of a load
        step(1'b1, 1'b0, 1'b0, '0);
        if (CLR_EN) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 8'sd55);
        step(1'b0, 1'b0, 1'b1, 8'sd66);
        chk("pre_rst_data", o_data, 8'sd66);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ready", i_ready, 1'b0);
        chk_outs("async_rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; i_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_en", o_en, 1'b0);
        end
        // first edge after reset release honours start
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_after_rst", busy, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("abort_to_idle", busy, 1'b0);

        m_busy = 1'b0; m_pre = 0; m_taken = 0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            bit exp_rdy, acc;
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 24) == 0);
            i_valid = ($urandom_range(0, 9) < 7);
            i_data  = WIDTH'($urandom);
            #1;
            exp_rdy = m_busy && (m_pre == 0) && (m_taken < ROWS) && !abort;
            chk("rand_ready", i_ready, exp_rdy);
            acc = i_valid && exp_rdy;
            m_en = 1'b0; m_clr = 1'b0; m_done = 1'b0;
            if (abort) begin
                m_busy = 1'b0; m_pre = 0; m_taken = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_pre  = CLR_EN ? 1 : 0;
                end
            end else if (m_pre > 0) begin
                m_pre--;
                m_clr = 1'b1;
            end else if (m_taken == ROWS) begin
                m_busy = 1'b0; m_taken = 0;
            end else if (acc) begin
                m_en   = 1'b1;
                m_data = i_data;
                m_taken++;
                m_done = (m_taken == ROWS);
            end
            @(posedge clk);
            #1;
            chk_outs("rand", m_en, m_data, m_clr, m_done, m_busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
